clk_div_prog: RTL
=================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter CNT_W, default 8: width of divisor, high-time and counter fields.
REQ-003 Parameter DEF_DIV, default 4: reset divisor of every channel, 1..2^CNT_W-1.
REQ-004 Parameter DEF_HIGH, default 2: reset high-time of every channel, 0..2^CNT_W-1.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 en  input  1  global count enable.
REQ-008 sync  input  1  one-cycle restart pulse for phase alignment of all channels.
REQ-009 wr_en  input  1  configuration write strobe.
REQ-010 wr_ch  input  clog2(NUM_CH) (min 1)  target channel of a write.
REQ-011 wr_div  input  CNT_W  new divisor D: output period in clk cycles.
REQ-012 wr_high  input  CNT_W  new high-time H in clk cycles.
REQ-013 clk_out  output  NUM_CH  registered divided clocks, one bit per channel.
REQ-014 tick  output  NUM_CH  registered one-cycle strobe at each period start.
REQ-015 pending  output  NUM_CH  shadow configuration written but not yet applied.

Function
REQ-016 Each channel SHALL hold active D, active H, shadow D, shadow H and a CNT_W counter cnt.
REQ-017 With en=1 and D>=1, cnt SHALL advance each cycle: cnt==D-1 -> 0, else cnt+1.
REQ-018 clk_out[ch] SHALL be 1 exactly in cycles where the registered cnt < H; H=0 -> constant 0; H>=D -> constant 1.
REQ-019 tick[ch] SHALL be 1 exactly in cycles where cnt has just wrapped (or been forced) to 0 and D>=1.
REQ-020 D=0 SHALL disable the channel: cnt held at 0, clk_out=0, tick=0.
REQ-021 D=1 SHALL give tick=1 every enabled cycle and clk_out=1 if H>=1.
REQ-022 With en=0, all counters, clk_out and tick SHALL hold (tick forced 0); writes still accepted.
REQ-023 A write SHALL load the shadow D/H of wr_ch and set pending[wr_ch] on the next edge; an out-of-range wr_ch SHALL be ignored.
REQ-024 A write to a channel already pending SHALL overwrite the shadow; pending stays 1.
REQ-025 Period boundary = enabled edge where cnt==D-1; if pending, active<=shadow, cnt<=0, pending<=0 on that edge.
REQ-026 A disabled channel (active D=0) with pending=1 SHALL apply the shadow on the next edge with en=1.
REQ-027 A write in the same cycle as a boundary for that channel SHALL NOT be applied at that boundary; it stays pending for the next one.
REQ-028 sync=1 SHALL, independent of en, force cnt<=0 on all channels and apply all pending shadows on that edge; tick=1 next cycle for channels with D>=1.
REQ-029 Channel updates SHALL occur only at boundaries or sync, so clk_out never shows a high or low pulse shorter than min(old, new) phase length.
REQ-030 Different channels SHALL operate fully independently except for en, sync and the shared write port.

Reset
REQ-031 While reset=1: active D=DEF_DIV, active H=DEF_HIGH, shadows equal active, cnt=DEF_DIV-1, clk_out=0, tick=0, pending=0.
REQ-032 The first enabled edge after reset release SHALL wrap cnt to 0, so tick=1 and the period starts high when DEF_HIGH>=1.
REQ-033 Reset asserted mid-period or with writes pending SHALL discard the shadows and return to REQ-031 values immediately.

Verification
REQ-034 Reset, en=1, defaults -> clk_out on every channel 1,1,0,0 repeating; tick on first cycle of each high phase.
REQ-035 Write ch1 D=5 H=2 at cnt=1 -> pending[1]=1 until cnt==3 boundary; then ch1 pattern 1,1,0,0,0; other channels unchanged.
REQ-036 Write ch2 D=3 H=3, then D=0 -> ch2 constant 1 for one period, then clk_out=0, tick=0, pending[2]=0.
REQ-037 Channels at D=4 and D=6 with offset phase, pulse sync -> all cnt=0, tick=1 on both the next cycle, pending shadows applied.
REQ-038 en=0 for 3 cycles mid-high -> clk_out held 1, tick 0, pattern resumes with no lost or extra cycle.
REQ-039 Assert reset during ch0 pending write and mid-period -> outputs 0, pending 0 immediately; after release defaults per REQ-034.

Source files
------------

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_prog
// Purpose  : Bank of NUM_CH independent programmable clock dividers. Each
//            channel produces a registered divided clock (period D, high for
//            the first H cycles of the period) plus a one-cycle tick at every
//            period start. New D/H values are written into a per-channel
//            shadow and only take effect at the channel's next period
//            boundary (or on a global sync pulse), so the output never
//            glitches.
// Ports    : clk      - system clock, rising edge
//            reset    - asynchronous, active-high
//            en       - global count enable
//            sync     - one-cycle restart of all channels (ignores en)
//            wr_en    - configuration write strobe
//            wr_ch    - channel addressed by the write
//            wr_div   - new divisor D (0 disables the channel)
//            wr_high  - new high-time H
//            clk_out  - divided clocks, one bit per channel
//            tick     - period-start strobes, one bit per channel
//            pending  - shadow configuration waiting to be applied
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 8,
   parameter int DEF_DIV  = 4,
   parameter int DEF_HIGH = 2
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic                                              en,
   input  logic                                              sync,
   input  logic                                              wr_en,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]    wr_ch,
   input  logic [CNT_W-1:0]                                  wr_div,
   input  logic [CNT_W-1:0]                                  wr_high,
   output logic [NUM_CH-1:0]                                 clk_out,
   output logic [NUM_CH-1:0]                                 tick,
   output logic [NUM_CH-1:0]                                 pending
);

   localparam int c_ch_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // One-hot write select; addresses beyond NUM_CH-1 select nothing.
   logic [NUM_CH-1:0] w_wr_sel;

   always_comb begin
      w_wr_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_en && (wr_ch == c_ch_w'(i))) begin
            w_wr_sel[i] = 1'b1;
         end
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [CNT_W-1:0] r_act_div;
      logic [CNT_W-1:0] r_act_high;
      logic [CNT_W-1:0] r_shd_div;
      logic [CNT_W-1:0] r_shd_high;
      logic [CNT_W-1:0] r_cnt;
      logic             r_pend;
      logic             r_clk;
      logic             r_tick;

      logic             w_dis;
      logic             w_at_end;
      logic             w_restart;
      logic             w_apply;
      logic [CNT_W-1:0] w_div_nxt;
      logic [CNT_W-1:0] w_high_nxt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             w_clk_nxt;
      logic             w_tick_nxt;

      always_comb begin
         w_dis      = (r_act_div == '0);
         w_at_end   = !w_dis && (r_cnt == (r_act_div - CNT_W'(1)));
         // A restart puts the counter at 0: period boundary, sync pulse, or
         // a disabled channel waking up because a new configuration waits.
         w_restart  = sync | (en & (w_at_end | (w_dis & r_pend)));
         // Uses the shadow as it was before this edge, so a write landing on
         // the boundary cycle waits for the following boundary.
         w_apply    = w_restart & r_pend;
         w_div_nxt  = w_apply ? r_shd_div  : r_act_div;
         w_high_nxt = w_apply ? r_shd_high : r_act_high;

         if (w_restart) begin
            w_cnt_nxt = '0;
         end else if (en && !w_dis) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end else begin
            w_cnt_nxt = r_cnt;
         end

         // Outputs reflect the counter value being registered this edge;
         // with the count frozen they simply hold.
         if (en || sync) begin
            w_clk_nxt = (w_div_nxt != '0) && (w_cnt_nxt < w_high_nxt);
         end else begin
            w_clk_nxt = r_clk;
         end
         w_tick_nxt = w_restart && (w_div_nxt != '0);
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_act_div  <= CNT_W'(DEF_DIV);
            r_act_high <= CNT_W'(DEF_HIGH);
            r_shd_div  <= CNT_W'(DEF_DIV);
            r_shd_high <= CNT_W'(DEF_HIGH);
            r_cnt      <= CNT_W'(DEF_DIV - 1);
            r_pend     <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
         end else begin
            r_act_div  <= w_div_nxt;
            r_act_high <= w_high_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clk      <= w_clk_nxt;
            r_tick     <= w_tick_nxt;
            if (w_wr_sel[ch]) begin
               r_shd_div  <= wr_div;
               r_shd_high <= wr_high;
               r_pend     <= 1'b1;
            end else if (w_apply) begin
               r_pend     <= 1'b0;
            end
         end
      end

      assign clk_out[ch] = r_clk;
      assign tick[ch]    = r_tick;
      assign pending[ch] = r_pend;
   end

endmodule
`default_nettype wire
